// File: rtl/ssp_id_rev_ctrl_if.sv
// ssp_id_rev_ctrl_if: APB slave bus for the SSP ID window (0xFE0-0xFFC).
//   PSEL     ID-window select
//   PENABLE  access phase
//   PWRITE   write strobe (writes are ignored by the slave)
//   PADDR    word address PADDR[11:2]
//   PRDATA   read data, driven by the slave
//   PREADY   access-phase ready, driven by the slave
// Modports: master drives the request side, slave drives PRDATA/PREADY.
interface ssp_id_rev_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    input  PRDATA,
    input  PREADY
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    output PRDATA,
    output PREADY
  );
endinterface

// File: rtl/ssp_id_rev_ctrl.sv
// ssp_id_rev_ctrl: SSP revision tie-off qualification and PeriphID/PCellID
// register server.
//
// After reset release it waits SETTLE_CYCLES for the revision tie-off nets to
// settle, then takes sample pairs of RevIn until two consecutive samples
// agree (or MAX_RETRY+1 pairs disagree, which holds 4'hF and flags RevErr).
// ID reads stall (PREADY=0 in the access phase) until a revision is held.
//
// Ports:
//   PCLK       APB clock
//   PRESETn    asynchronous active-low reset
//   RevIn      revision AND-cell outputs (quasi-static)
//   ReCapture  (SSP_ID_RECAPTURE_EN only) pulse in VALID to requalify RevIn
//   apb        APB slave modport: PSEL/PENABLE/PWRITE/PADDR in, PRDATA/PREADY out
//   IdValid    revision captured and held
//   RevErr     revision failed qualification
//
// Optional feature macro: SSP_ID_RECAPTURE_EN (adds the ReCapture input).
module ssp_id_rev_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned REV_WIDTH     = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [REV_WIDTH-1:0] RevIn,
`ifdef SSP_ID_RECAPTURE_EN
  input  logic                 ReCapture,
`endif
  ssp_id_rev_ctrl_if.slave     apb,
  output logic                 IdValid,
  output logic                 RevErr
);

  localparam logic [1:0] StSettle  = 2'd0;
  localparam logic [1:0] StSampleA = 2'd1;
  localparam logic [1:0] StSampleB = 2'd2;
  localparam logic [1:0] StValid   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [3:0]           settle_cnt_q, settle_cnt_d;
  logic [2:0]           retry_q, retry_d;
  logic [REV_WIDTH-1:0] samp_a_q, samp_a_d;
  logic [REV_WIDTH-1:0] rev_q, rev_d;
  logic                 id_valid_q, id_valid_d;
  logic                 rev_err_q, rev_err_d;
  logic [31:0]          prdata_q, prdata_d;
  logic [31:0]          rd_data;
  logic                 rd_req;
  logic                 rd_load;

  // Qualification FSM
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    retry_d      = retry_q;
    samp_a_d     = samp_a_q;
    rev_d        = rev_q;
    id_valid_d   = id_valid_q;
    rev_err_d    = rev_err_q;
    case (state_q)
      StSettle: begin
        if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = StSampleA;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StSampleA: begin
        samp_a_d = RevIn;
        state_d  = StSampleB;
      end
      StSampleB: begin
        if (RevIn == samp_a_q) begin
          rev_d      = RevIn;
          id_valid_d = 1'b1;
          state_d    = StValid;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = StSampleA;
        end else begin
          rev_d      = '1;
          rev_err_d  = 1'b1;
          id_valid_d = 1'b1;
          state_d    = StValid;
        end
      end
      StValid: begin
`ifdef SSP_ID_RECAPTURE_EN
        // Held revision is kept until the new pair resolves.
        if (ReCapture) begin
          id_valid_d = 1'b0;
          rev_err_d  = 1'b0;
          retry_d    = '0;
          state_d    = StSampleA;
        end
`endif
      end
      default: state_d = StSettle;
    endcase
  end

  // ID register map; built from rev_d so a load on the resolving edge already
  // sees the newly qualified revision.
  always_comb begin
    rd_data = '0;
    case (apb.PADDR)
      10'h3F8: rd_data[7:0] = 8'h22;
      10'h3F9: rd_data[7:0] = 8'h10;
      10'h3FA: begin
        rd_data[REV_WIDTH+3:4] = rev_d;
        rd_data[3:0]           = 4'h4;
      end
      10'h3FB: rd_data[7:0] = 8'h00;
      10'h3FC: rd_data[7:0] = 8'h0D;
      10'h3FD: rd_data[7:0] = 8'hF0;
      10'h3FE: rd_data[7:0] = 8'h05;
      10'h3FF: rd_data[7:0] = 8'hB1;
      default: rd_data = '0;
    endcase
  end

  assign rd_req = apb.PSEL & ~apb.PWRITE;

  // Normal load in the setup phase; a read pending while no revision is held
  // is loaded on the edge IdValid rises so it completes in the next cycle.
  assign rd_load = rd_req & ((~apb.PENABLE & id_valid_q) | (~id_valid_q & id_valid_d));

  always_comb begin
    prdata_d = prdata_q;
    if (!apb.PSEL) begin
      prdata_d = '0;
    end else if (rd_load) begin
      prdata_d = rd_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      retry_q      <= '0;
      samp_a_q     <= '0;
      rev_q        <= '0;
      id_valid_q   <= 1'b0;
      rev_err_q    <= 1'b0;
      prdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      retry_q      <= retry_d;
      samp_a_q     <= samp_a_d;
      rev_q        <= rev_d;
      id_valid_q   <= id_valid_d;
      rev_err_q    <= rev_err_d;
      prdata_q     <= prdata_d;
    end
  end

  // PREADY is held high while in reset so an aborted read is released at once.
  assign apb.PREADY = ~PRESETn | ~(apb.PSEL & apb.PENABLE & ~apb.PWRITE & ~id_valid_q);
  assign apb.PRDATA = prdata_q;
  assign IdValid    = id_valid_q;
  assign RevErr     = rev_err_q;

endmodule

// File: tb/tb_ssp_id_rev_ctrl.sv
// tb_ssp_id_rev_ctrl: directed self-checking bench for ssp_id_rev_ctrl
// (SETTLE_CYCLES=4, MAX_RETRY=3). Inputs change on the falling edge; outputs
// are sampled on or just after the falling edge.
module tb_ssp_id_rev_ctrl;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [3:0] RevIn = 4'h0;
  logic       IdValid;
  logic       RevErr;
`ifdef SSP_ID_RECAPTURE_EN
  logic       ReCapture = 1'b0;
`endif
  int errors = 0;
  int checks = 0;

  ssp_id_rev_ctrl_if bus ();

  ssp_id_rev_ctrl #(
    .SETTLE_CYCLES(4),
    .MAX_RETRY(3),
    .REV_WIDTH(4)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .RevIn(RevIn),
`ifdef SSP_ID_RECAPTURE_EN
    .ReCapture(ReCapture),
`endif
    .apb(bus),
    .IdValid(IdValid),
    .RevErr(RevErr)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Hold reset for two cycles and release it on a falling edge (N0).
  task automatic do_reset();
    PRESETn     = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  // Starts at a falling edge; ends at a falling edge with the bus idle.
  task automatic apb_read(input logic [9:0] addr, output logic [31:0] data,
                          output int stalls, output bit timeout);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = addr;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1;
    stalls = 0;
    while (bus.PREADY !== 1'b1 && stalls < 64) begin
      stalls++;
      @(negedge PCLK);
      #1;
    end
    timeout = (bus.PREADY !== 1'b1);
    data    = bus.PRDATA;
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [9:0] addr, output logic ready,
                           output logic [31:0] data);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1;
    ready = bus.PREADY;
    data  = bus.PRDATA;
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  // Releases reset and drives RevIn per mode (0 stable, 1 toggle 1/2,
  // 2 glitch during the first SAMPLE_B cycle). rise = first falling edge
  // index after release at which IdValid reads 1 (-1 if never).
  task automatic run_capture(input int mode, input logic [3:0] base, output int rise);
    RevIn = (mode == 1) ? 4'h1 : base;
    do_reset();
    rise = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      if (IdValid === 1'b1 && rise < 0) rise = k;
      if (mode == 1)      RevIn = (k % 2 == 1) ? 4'h2 : 4'h1;
      else if (mode == 2) RevIn = (k == 5) ? 4'hA : base;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.PRDATA !== 32'h0) begin errors++;
      $display("FAIL reset_prdata: got %h want %h", bus.PRDATA, 32'h0); end
    checks++; if (bus.PREADY !== 1'b1) begin errors++;
      $display("FAIL reset_pready: got %b want 1", bus.PREADY); end
    checks++; if (IdValid !== 1'b0) begin errors++;
      $display("FAIL reset_idvalid: got %b want 0", IdValid); end
    checks++; if (RevErr !== 1'b0) begin errors++;
      $display("FAIL reset_reverr: got %b want 0", RevErr); end
  endtask

  task automatic test_latency();
    int rise;
    logic [31:0] d;
    int st;
    bit to;
    run_capture(0, 4'h3, rise);
    checks++; if (rise !== 6) begin errors++;
      $display("FAIL latency_rise: got %0d want 6", rise); end
    checks++; if (RevErr !== 1'b0) begin errors++;
      $display("FAIL latency_reverr: got %b want 0", RevErr); end
    apb_read(10'h3FA, d, st, to);
    checks++; if (to !== 1'b0 || st !== 0) begin errors++;
      $display("FAIL latency_rd_stall: got %0d stalls want 0", st); end
    checks++; if (d !== 32'h0000_0034) begin errors++;
      $display("FAIL latency_rd_3fa: got %h want %h", d, 32'h34); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int st;
    bit to;
    RevIn = 4'h3;
    do_reset();
    @(negedge PCLK);
    apb_read(10'h3F8, d, st, to);
    checks++; if (to !== 1'b0 || st !== 4) begin errors++;
      $display("FAIL stall_cycles: got %0d stalls (timeout %b) want 4", st, to); end
    checks++; if (d !== 32'h0000_0022) begin errors++;
      $display("FAIL stall_rd_3f8: got %h want %h", d, 32'h22); end
    checks++; if (IdValid !== 1'b1) begin errors++;
      $display("FAIL stall_idvalid: got %b want 1", IdValid); end
  endtask

  task automatic test_retry_error();
    int rise;
    logic [31:0] d;
    int st;
    bit to;
    run_capture(1, 4'h0, rise);
    checks++; if (rise !== 12) begin errors++;
      $display("FAIL err_rise: got %0d want 12", rise); end
    checks++; if (RevErr !== 1'b1) begin errors++;
      $display("FAIL err_reverr: got %b want 1", RevErr); end
    apb_read(10'h3FA, d, st, to);
    checks++; if (to !== 1'b0 || d !== 32'h0000_00F4) begin errors++;
      $display("FAIL err_rd_3fa: got %h want %h", d, 32'hF4); end
  endtask

  task automatic test_glitch();
    int rise;
    logic [31:0] d;
    int st;
    bit to;
    run_capture(2, 4'h5, rise);
    checks++; if (rise !== 8) begin errors++;
      $display("FAIL glitch_rise: got %0d want 8", rise); end
    checks++; if (RevErr !== 1'b0) begin errors++;
      $display("FAIL glitch_reverr: got %b want 0", RevErr); end
    apb_read(10'h3FA, d, st, to);
    checks++; if (to !== 1'b0 || d !== 32'h0000_0054) begin errors++;
      $display("FAIL glitch_rd_3fa: got %h want %h", d, 32'h54); end
  endtask

  // Expects the revision 4'h5 left by test_glitch.
  task automatic test_id_map();
    logic [9:0]  addrs [9];
    logic [31:0] exps  [9];
    logic [31:0] d;
    logic        rdy;
    int st;
    bit to;
    addrs = '{10'h3F8, 10'h3F9, 10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
    exps  = '{32'h22, 32'h10, 32'h54, 32'h00, 32'h0D, 32'hF0, 32'h05, 32'hB1, 32'h00};
    for (int i = 0; i < 9; i++) begin
      apb_read(addrs[i], d, st, to);
      checks++; if (to !== 1'b0 || d !== exps[i]) begin errors++;
        $display("FAIL idmap_%h: got %h want %h", addrs[i], d, exps[i]); end
    end
    apb_write(10'h3F8, rdy, d);
    checks++; if (rdy !== 1'b1) begin errors++;
      $display("FAIL write_pready: got %b want 1", rdy); end
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL write_prdata: got %h want 0", d); end
    apb_read(10'h3F8, d, st, to);
    checks++; if (d !== 32'h22) begin errors++;
      $display("FAIL write_nochange_3f8: got %h want %h", d, 32'h22); end
    apb_read(10'h3FA, d, st, to);
    checks++; if (d !== 32'h54 || IdValid !== 1'b1) begin errors++;
      $display("FAIL write_nochange_3fa: got %h want %h", d, 32'h54); end
  endtask

  task automatic test_reset_mid_read();
    int rise;
    RevIn = 4'h3;
    do_reset();
    @(negedge PCLK);
    bus.PSEL  = 1'b1;
    bus.PADDR = 10'h3F8;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    #1;
    checks++; if (bus.PREADY !== 1'b0) begin errors++;
      $display("FAIL midrst_stalled: got %b want 0", bus.PREADY); end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++; if (bus.PREADY !== 1'b1 || bus.PRDATA !== 32'h0 || IdValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stall_abort: got pready %b prdata %h idvalid %b want 1 0 0",
               bus.PREADY, bus.PRDATA, IdValid);
    end
    // Abort a read that already holds data.
    run_capture(0, 4'h3, rise);
    bus.PSEL  = 1'b1;
    bus.PADDR = 10'h3F8;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1;
    checks++; if (bus.PRDATA !== 32'h22) begin errors++;
      $display("FAIL midrst_data_before: got %h want %h", bus.PRDATA, 32'h22); end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++; if (bus.PRDATA !== 32'h0 || bus.PREADY !== 1'b1 || IdValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_data_abort: got prdata %h pready %b idvalid %b want 0 1 0",
               bus.PRDATA, bus.PREADY, IdValid);
    end
    run_capture(0, 4'h3, rise);
    checks++; if (rise !== 6) begin errors++;
      $display("FAIL midrst_restart_rise: got %0d want 6", rise); end
  endtask

`ifdef SSP_ID_RECAPTURE_EN
  task automatic test_recapture();
    int rise;
    logic [31:0] d;
    int st;
    bit to;
    run_capture(0, 4'h3, rise);
    RevIn     = 4'h6;
    ReCapture = 1'b1;
    @(negedge PCLK);
    ReCapture = 1'b0;
    checks++; if (IdValid !== 1'b0) begin errors++;
      $display("FAIL recap_low1: got %b want 0", IdValid); end
    @(negedge PCLK);
    checks++; if (IdValid !== 1'b0) begin errors++;
      $display("FAIL recap_low2: got %b want 0", IdValid); end
    @(negedge PCLK);
    checks++; if (IdValid !== 1'b1 || RevErr !== 1'b0) begin errors++;
      $display("FAIL recap_high: got idvalid %b reverr %b want 1 0", IdValid, RevErr); end
    apb_read(10'h3FA, d, st, to);
    checks++; if (to !== 1'b0 || d !== 32'h0000_0064) begin errors++;
      $display("FAIL recap_rd_3fa: got %h want %h", d, 32'h64); end
  endtask
`endif

  initial begin
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    test_reset();
    test_latency();
    test_stall();
    test_retry_error();
    test_glitch();
    test_id_map();
    test_reset_mid_read();
`ifdef SSP_ID_RECAPTURE_EN
    test_recapture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
